// File: rtl/cdc_word_sender_pkg.sv
// Shared definitions for the word-crossing sender.
// State encodings and synchronizer depth.
package cdc_word_sender_pkg;

  localparam int CDC_SYNC_DEPTH = 2;
  localparam int DEFAULT_RESYNC_CYCLES = CDC_SYNC_DEPTH + 1;

  typedef enum logic [1:0] {
    ST_RESYNC   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

endpackage

// File: rtl/cdc_synchronizer.sv
// Multi-flop level synchronizer for a single asynchronous bit.
// Flops carry no reset so the chain settles on the live input level.
module cdc_synchronizer
  import cdc_word_sender_pkg::*;
#(
  parameter int STAGES = CDC_SYNC_DEPTH
) (
  input  logic clock,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock) begin
    sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_word_sender.sv
// Transmit end of the two-phase toggle req/ack word crossing.
// Holds each word on a flop until the destination echoes the request.
module cdc_word_sender
  import cdc_word_sender_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int RESYNC_CYCLES = DEFAULT_RESYNC_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [WORD_WIDTH-1:0] cdc_data_out,
  output logic                  cdc_req_out,
  input  logic                  cdc_ack_in,
  output logic                  transfer_done
);

  localparam int CNT_W =
    (RESYNC_CYCLES > 2) ? $clog2(RESYNC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RESYNC_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic                    ack_sync;

  cdc_synchronizer #(
    .STAGES(CDC_SYNC_DEPTH)
  ) u_ack_sync (
    .clock(clock),
    .d    (cdc_ack_in),
    .q    (ack_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_RESYNC: begin
        // track the ack level so the first toggle is a real one
        req_d = ack_sync;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (data_in_valid) begin
          data_d  = data_in;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RESYNC;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= ack_sync;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign data_in_ready = (state_q == ST_IDLE);
  assign cdc_data_out  = data_q;
  assign cdc_req_out   = req_q;
  assign transfer_done = done_q;

endmodule

// File: tb/tb_cdc_word_sender.sv
// Self-checking bench for cdc_word_sender.
// Table vectors, directed corner sequences and a randomized destination.
module tb_cdc_word_sender;

  localparam int RC = 3;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] cdc_data_out;
  logic        cdc_req_out;
  logic        cdc_ack_in;
  logic        transfer_done;

  cdc_word_sender #(
    .WORD_WIDTH   (32),
    .RESYNC_CYCLES(RC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .cdc_data_out (cdc_data_out),
    .cdc_req_out  (cdc_req_out),
    .cdc_ack_in   (cdc_ack_in),
    .transfer_done(transfer_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;
  bit chk_en;

  int          m_resync_left;
  bit          m_busy;
  logic [31:0] m_data;
  bit          m_req;
  bit          m_done;
  bit          ack_hist [2];

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_data;
    logic        e_done;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Destination sees a word as settled once the ack level,
  // two edges old, matches the request level.
  task automatic model_edge(input bit rst, input bit v,
                            input logic [31:0] d, input bit a);
    bit as;
    as = ack_hist[1];
    m_done = 1'b0;
    if (rst) begin
      m_resync_left = RC;
      m_busy = 1'b0;
      m_data = '0;
      m_req  = as;
    end else if (m_resync_left > 0) begin
      m_req = as;
      m_resync_left--;
    end else if (!m_busy) begin
      if (v) begin
        m_data = d;
        m_req  = !m_req;
        m_busy = 1'b1;
      end
    end else if (as == m_req) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    ack_hist[1] = ack_hist[0];
    ack_hist[0] = a;
  endtask

  task automatic cycle(input bit rst, input bit v,
                       input logic [31:0] d, input bit a);
    if (chk_en) begin
      chk("model_ready", {31'b0, data_in_ready},
          {31'b0, (m_resync_left == 0) && !m_busy});
      chk("model_req", {31'b0, cdc_req_out}, {31'b0, m_req});
      chk("model_data", cdc_data_out, m_data);
      chk("model_done", {31'b0, transfer_done}, {31'b0, m_done});
    end
    reset         = rst;
    data_in_valid = v;
    data_in       = d;
    cdc_ack_in    = a;
    model_edge(rst, v, d, a);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int k;
    int dones;
    int acc_cyc [$];
    bit ack_lvl;
    int dly;
    bit acc;

    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    m_resync_left = RC;
    m_busy = 1'b0;
    m_data = '0;
    m_req = 1'b1;
    m_done = 1'b0;
    ack_hist[0] = 1'b1;
    ack_hist[1] = 1'b1;
    reset = 1'b1;
    data_in = '0;
    data_in_valid = 1'b0;
    cdc_ack_in = 1'b1;

    tbl[0]  = '{1, 0, 32'h0, 1, 0, 1, 32'h0, 0};
    tbl[1]  = '{1, 0, 32'h0, 1, 0, 1, 32'h0, 0};
    tbl[2]  = '{0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
    tbl[3]  = '{0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
    tbl[4]  = '{0, 0, 32'h0, 1, 0, 1, 32'h0, 0};
    tbl[5]  = '{0, 1, 32'hDEADBEEF, 1, 1, 1, 32'h0, 0};
    tbl[6]  = '{0, 1, 32'h12345678, 1, 0, 0, 32'hDEADBEEF, 0};
    tbl[7]  = '{0, 0, 32'h0, 1, 0, 0, 32'hDEADBEEF, 0};
    tbl[8]  = '{0, 1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 0};
    tbl[9]  = '{0, 0, 32'h0, 1, 0, 0, 32'hDEADBEEF, 0};
    tbl[10] = '{0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0};
    tbl[11] = '{0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0};
    tbl[12] = '{0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0};
    tbl[13] = '{0, 0, 32'h0, 0, 1, 0, 32'hDEADBEEF, 1};
    tbl[14] = '{0, 0, 32'h0, 0, 1, 0, 32'hDEADBEEF, 0};

    // flush the ack synchronizer under reset
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk_en = 1'b1;
    cycle(1, 0, 0, 1);

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d_ready", i),
          {31'b0, data_in_ready}, {31'b0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_req", i),
          {31'b0, cdc_req_out}, {31'b0, tbl[i].e_req});
      chk($sformatf("tbl%0d_data", i),
          cdc_data_out, tbl[i].e_data);
      chk($sformatf("tbl%0d_done", i),
          {31'b0, transfer_done}, {31'b0, tbl[i].e_done});
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].ack);
    end

    // immediate echo, valid held high, words 1,2,3
    k = 0;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      acc = data_in_ready && (k < 3);
      if (transfer_done) dones++;
      if (acc) acc_cyc.push_back(c);
      cycle(0, k < 3, 32'(k + 1), cdc_req_out);
      if (acc) begin
        chk("echo_data", cdc_data_out, 32'(k + 1));
        chk("echo_req", {31'b0, cdc_req_out},
            (k % 2 == 0) ? 32'd1 : 32'd0);
        k++;
      end
    end
    chk("echo_accepts", acc_cyc.size(), 3);
    chk("echo_dones", dones, 3);
    if (acc_cyc.size() == 3) begin
      chk("echo_gap1", acc_cyc[1] - acc_cyc[0], 4);
      chk("echo_gap2", acc_cyc[2] - acc_cyc[1], 4);
    end

    // ack toggled while idle is ignored
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      chk("idle_ack_req", {31'b0, cdc_req_out}, 1);
      chk("idle_ack_ready", {31'b0, data_in_ready}, 1);
      chk("idle_ack_done", {31'b0, transfer_done}, 0);
    end
    cycle(0, 1, 32'hA5A50001, 0);
    chk("post_idle_req", {31'b0, cdc_req_out}, 0);
    chk("post_idle_data", cdc_data_out, 32'hA5A50001);
    cycle(0, 0, 0, 0);
    chk("post_idle_done", {31'b0, transfer_done}, 1);

    // reset while waiting for ack
    cycle(0, 1, 32'h0BADF00D, 0);
    chk("wait_req", {31'b0, cdc_req_out}, 1);
    cycle(0, 0, 0, 0);
    chk("wait_ready", {31'b0, data_in_ready}, 0);
    cycle(1, 0, 0, 0);
    chk("rst_wait_req", {31'b0, cdc_req_out}, 0);
    chk("rst_wait_ready", {31'b0, data_in_ready}, 0);
    chk("rst_wait_data", cdc_data_out, 0);
    for (int i = 0; i < RC; i++) begin
      chk("rst_wait_done", {31'b0, transfer_done}, 0);
      cycle(0, 0, 0, 0);
    end
    chk("rst_wait_idle", {31'b0, data_in_ready}, 1);

    // randomized traffic against a lagging destination
    ack_lvl = 1'b0;
    dly = -1;
    for (int c = 0; c < 400; c++) begin
      if (cdc_req_out != ack_lvl) begin
        if (dly < 0) dly = int'($urandom_range(0, 6));
        if (dly == 0) begin
          ack_lvl = cdc_req_out;
          dly = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 1) == 1,
            $urandom, ack_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdc_word_sender.md
Name: cdc_word_sender

Overview:
- Source-domain (transmit) end of the two-phase toggle req/ack word-crossing protocol.
- Accepts one word per handshake from local logic and holds it stable on cdc_data_out. Toggles cdc_req_out to announce the word, then waits for the destination's cdc_ack_in toggle before accepting the next word.
- Sits on the sending side of every multi-bit crossing. The destination end captures cdc_data_out only after synchronizing cdc_req_out.

Parameters:
- WORD_WIDTH, 32, width of the transferred word.
- RESYNC_CYCLES, 3, cycles spent in RESYNC after reset. Must be >= synchronizer depth (2) + 1.

Ports:
- clock  input  1  sole clock (source domain).
- reset  input  1  synchronous, active-high reset.
- data_in  input  WORD_WIDTH  word to send.
- data_in_valid  input  1  data_in is valid this cycle.
- data_in_ready  output  1  sender can accept a word this cycle.
- cdc_data_out  output  WORD_WIDTH  registered word. Stable for the whole handshake.
- cdc_req_out  output  1  registered request level. A toggle announces a new word.
- cdc_ack_in  input  1  asynchronous ack level from the destination. Synchronized internally.
- transfer_done  output  1  one-cycle pulse when a word's ack is seen.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, on ports clock and reset.
- Ack synchronization: cdc_ack_in passes through a 2-flop synchronizer to give ack_sync. No other logic ever samples cdc_ack_in.
- States: RESYNC, IDLE, WAIT_ACK.
- Reset values:
  - state=RESYNC, counter=0.
  - data_in_ready=0, transfer_done=0, cdc_data_out=0.
  - cdc_req_out <= ack_sync, not 0. This avoids a spurious toggle at the destination.
- RESYNC:
  - Each cycle cdc_req_out <= ack_sync and counter increments.
  - When counter == RESYNC_CYCLES-1, go to IDLE.
  - data_in_ready=0 throughout.
- IDLE:
  - data_in_ready=1 (decoded from state, combinational).
  - On data_in_valid & data_in_ready: cdc_data_out <= data_in, cdc_req_out <= ~cdc_req_out, go to WAIT_ACK.
  - Both outputs change on the same edge.
- WAIT_ACK:
  - data_in_ready=0. cdc_data_out and cdc_req_out are held.
  - When ack_sync == cdc_req_out: go to IDLE and pulse transfer_done=1 for exactly one cycle (registered).
  - data_in_ready returns to 1 on the cycle transfer_done is high.
  - data_in_valid is ignored while in WAIT_ACK.
- Latency:
  - Word accepted at edge N appears on cdc_data_out and cdc_req_out after edge N.
  - After the destination toggles cdc_ack_in, completion takes 2 clock edges of synchronization, plus 1 edge to transfer_done and IDLE.
  - With an immediately echoing ack (cdc_ack_in = cdc_req_out), back-to-back throughput is one word per 4 cycles.
- Boundary conditions:
  - data_in_valid held high across completion: the next word is accepted on the first IDLE cycle.
  - An ack toggle arriving in IDLE (protocol violation) has no effect. cdc_req_out is not changed.
  - Reset during WAIT_ACK: the in-flight word is abandoned and cdc_req_out realigns to ack_sync. The destination may or may not have captured the word; upper layers must reset both ends together.
  - cdc_data_out never changes except on an accept edge or at reset.
- Constraint: cdc_data_out and cdc_req_out must come straight from flops, with no logic after them.

Decomposition:
- Shared package:
  - State encodings (RESYNC, IDLE, WAIT_ACK; 2 bits).
  - CDC_SYNC_DEPTH=2.
  - Default RESYNC_CYCLES = CDC_SYNC_DEPTH+1.
- Sub-module: the team's existing 1-bit cdc_synchronizer, instantiated once for cdc_ack_in.

Test Plan:
- Reset held 2 cycles with cdc_ack_in=1 -> cdc_req_out=1, data_in_ready=0 for 3 cycles after reset release, then 1. No cdc_req_out toggle occurs.
- IDLE, data_in=32'hDEADBEEF, valid for 1 cycle -> next cycle cdc_data_out=DEADBEEF, cdc_req_out toggles, ready=0. No completion while cdc_ack_in is held.
- Bench echoes ack 5 cycles after the req toggle -> transfer_done pulses exactly 3 cycles after the ack edge; ready=1 that same cycle; cdc_data_out is unchanged throughout.
- Immediate-echo ack, valid held high with data 1,2,3 -> each word accepted every 4 cycles, in order. cdc_req_out alternates 1,0,1; three transfer_done pulses.
- Reset asserted while in WAIT_ACK (req=1, ack=0) -> cdc_req_out=0 after the reset edge, state RESYNC, no transfer_done pulse.
- cdc_ack_in toggled while IDLE -> no state change, no transfer_done pulse; the next accept toggles cdc_req_out normally.
